series_accum: RTL

- Parametrised iterative series accumulator. Accepts a count N and a mode; accumulates term(i) for i = N down to 1, one term per clock.
- Result is presented with a valid/ack handshake.
- Successor to the fixed 3-bit sum-of-1..N block. Generalises operand and sum widths and adds three series modes, saturation with an overflow flag, defined N=0 handling, and an explicit ready output.

---
 rtl/series_accum_pkg.sv | 16 +
 rtl/series_term.sv | 30 +++
 rtl/series_accum.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/series_accum_pkg.sv
// Shared state encoding and series-mode constants for the series accumulator.
// Purely declarative: no logic, no latency, no flow control.
package series_accum_pkg;

    // 2'b10 is deliberately unused; the FSM treats it as illegal and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b11
    } state_t;

    localparam logic [1:0] MODE_SUM = 2'b00;
    localparam logic [1:0] MODE_SQ  = 2'b01;
    localparam logic [1:0] MODE_ODD = 2'b10;

endpackage

// File: rtl/series_term.sv
// Series term generator: i, i*i or 2i-1 at 2*N_WIDTH bits (reserved mode acts as i).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the owner decides when the term is consumed.
module series_term
    import series_accum_pkg::*;
#(
    parameter int N_WIDTH = 4
) (
    input  logic [N_WIDTH-1:0]   i,
    input  logic [1:0]           mode,
    output logic [2*N_WIDTH-1:0] term
);

    localparam int TW = 2 * N_WIDTH;

    logic [TW-1:0] i_ext;

    assign i_ext = TW'(i);

    // Kept separate so the multiplier can be pipelined without touching the FSM.
    always_comb begin
        term = i_ext;
        case (mode)
            MODE_SQ:  term = i_ext * i_ext;
            MODE_ODD: term = (i_ext << 1) - TW'(1);
            default:  term = i_ext;
        endcase
    end

endmodule

// File: rtl/series_accum.sv
// Iterative series accumulator: sums term(i) for i = N down to 1, one term per clock, saturating.
// Latency: sum_valid rises N edges after the accepting edge (same edge's result for N=0).
// Backpressure: one job at a time; n_ready is low until the result is acknowledged in DONE.
module series_accum
    import series_accum_pkg::*;
#(
    parameter int N_WIDTH   = 4,
    parameter int SUM_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_WIDTH-1:0]   n_in,
    input  logic [1:0]           mode_in,
    input  logic                 n_valid_in,
    output logic                 n_ready,
    output logic [SUM_WIDTH-1:0] sum_out,
    output logic                 sum_valid,
    input  logic                 sum_ack,
    output logic                 overflow,
    output logic                 busy
);

    localparam int TW = 2 * N_WIDTH;

    generate
        if (SUM_WIDTH < 2 * N_WIDTH) begin : g_width_check
            $error("series_accum: SUM_WIDTH must be at least 2*N_WIDTH");
        end
    endgenerate

    state_t               state_q;
    state_t               state_d;
    logic [N_WIDTH-1:0]   i_q;
    logic [1:0]           mode_q;
    logic [SUM_WIDTH-1:0] sum_q;
    logic                 ovf_q;
    logic                 vld_q;

    logic                 accept;
    logic                 step;
    logic                 set_vld;
    logic                 clr_vld;

    logic [TW-1:0]        term;
    logic [SUM_WIDTH:0]   sum_raw;
    logic                 carry;

    series_term #(
        .N_WIDTH (N_WIDTH)
    ) u_term (
        .i    (i_q),
        .mode (mode_q),
        .term (term)
    );

    assign sum_raw = {1'b0, sum_q} + (SUM_WIDTH + 1)'(term);
    assign carry   = sum_raw[SUM_WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        set_vld = 1'b0;
        clr_vld = 1'b0;
        n_ready = 1'b0;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                n_ready = 1'b1;
                if (n_valid_in) begin
                    accept = 1'b1;
                    if (n_in == '0) begin
                        state_d = DONE;
                        set_vld = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                busy = 1'b1;
                step = 1'b1;
                if (i_q == N_WIDTH'(1)) begin
                    state_d = DONE;
                    set_vld = 1'b1;
                end
            end
            DONE: begin
                busy = 1'b1;
                if (sum_ack) begin
                    state_d = IDLE;
                    clr_vld = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Once saturated the sum keeps stepping at all-ones so latency never depends on data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_q    <= '0;
            mode_q <= MODE_SUM;
            sum_q  <= '0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            if (accept) begin
                mode_q <= mode_in;
                i_q    <= n_in;
                sum_q  <= '0;
                ovf_q  <= 1'b0;
            end else if (step) begin
                sum_q <= carry ? '1 : sum_raw[SUM_WIDTH-1:0];
                ovf_q <= ovf_q | carry;
                i_q   <= i_q - N_WIDTH'(1);
            end
            if (set_vld) begin
                vld_q <= 1'b1;
            end else if (clr_vld) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign sum_out   = sum_q;
    assign sum_valid = vld_q;
    assign overflow  = ovf_q;

endmodule
